// File: rtl/prbs7_rx_checker.sv
// Receive-side PRBS-7 (x^7 + x^6 + 1) checker: seeds, self-synchronises, locks, then counts words and errors.
// Optional per-bit error counter enabled by defining PRBS_CHK_BITERR_EN.
module prbs7_rx_checker #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned LOCK_CNT = 8,
    parameter int unsigned LOSS_CNT = 4
) (
    input  logic              SYSCLK,
    input  logic              NSYSRESET,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              clr_cnt,
    output logic              lock,
    output logic              err_pulse,
    output logic [31:0]       word_cnt,
    output logic [31:0]       err_cnt
`ifdef PRBS_CHK_BITERR_EN
    ,
    output logic [31:0]       bit_err_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEED,
        ST_HUNT,
        ST_LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        hist_q, hist_d;
    logic [7:0]        match_cnt_q, match_cnt_d;
    logic [7:0]        bad_run_q, bad_run_d;
    logic [31:0]       word_cnt_q, word_cnt_d;
    logic [31:0]       err_cnt_q, err_cnt_d;
    logic              err_pulse_q, err_pulse_d;
    logic              lock_q, lock_d;

    logic [6:0]        pred_sh;
    logic [DATA_W-1:0] pred;
    logic              word_match;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // Serial PRBS expansion of the 7-bit history; the first bit generated lands in the MSB.
    always_comb begin
        pred_sh = hist_q;
        pred    = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            pred_sh = {pred_sh[5:0], pred_sh[6] ^ pred_sh[5]};
            pred    = {pred[DATA_W-2:0], pred_sh[0]};
        end
    end

    assign word_match = (rx_data == pred);

`ifdef PRBS_CHK_BITERR_EN
    logic [31:0]       bit_err_cnt_q, bit_err_cnt_d;
    logic [DATA_W-1:0] diff;
    logic [6:0]        pop;
    logic [32:0]       bit_sum;

    always_comb begin
        diff = rx_data ^ pred;
        pop  = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            pop  = pop + {6'b0, diff[0]};
            diff = diff >> 1;
        end
        bit_sum = {1'b0, bit_err_cnt_q} + {26'b0, pop};
    end
`endif

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        match_cnt_d = match_cnt_q;
        bad_run_d   = bad_run_q;
        word_cnt_d  = word_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
`ifdef PRBS_CHK_BITERR_EN
        bit_err_cnt_d = bit_err_cnt_q;
`endif

        if (!start) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_SEED;
                ST_SEED: begin
                    if (rx_valid) begin
                        hist_d      = rx_data[6:0];
                        match_cnt_d = '0;
                        state_d     = ST_HUNT;
                    end
                end
                ST_HUNT: begin
                    if (rx_valid) begin
                        hist_d = rx_data[6:0];
                        if (word_match) begin
                            if (match_cnt_q == 8'(LOCK_CNT - 1)) begin
                                state_d   = ST_LOCKED;
                                bad_run_d = '0;
                            end else begin
                                match_cnt_d = match_cnt_q + 8'd1;
                            end
                        end else begin
                            match_cnt_d = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Free-running from the prediction so a single bad bit costs one word, not a resync.
                    if (rx_valid) begin
                        hist_d     = pred[6:0];
                        word_cnt_d = sat_inc(word_cnt_q);
                        if (!word_match) begin
                            err_cnt_d   = sat_inc(err_cnt_q);
                            err_pulse_d = 1'b1;
                            bad_run_d   = bad_run_q + 8'd1;
`ifdef PRBS_CHK_BITERR_EN
                            bit_err_cnt_d = bit_sum[32] ? '1 : bit_sum[31:0];
`endif
                            if (bad_run_q == 8'(LOSS_CNT - 1)) begin
                                state_d = ST_SEED;
                            end
                        end else begin
                            bad_run_d = '0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (clr_cnt) begin
            word_cnt_d = '0;
            err_cnt_d  = '0;
`ifdef PRBS_CHK_BITERR_EN
            bit_err_cnt_d = '0;
`endif
        end

        lock_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            state_q     <= ST_IDLE;
            hist_q      <= 7'h7F;
            match_cnt_q <= '0;
            bad_run_q   <= '0;
            word_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            lock_q      <= 1'b0;
`ifdef PRBS_CHK_BITERR_EN
            bit_err_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            match_cnt_q <= match_cnt_d;
            bad_run_q   <= bad_run_d;
            word_cnt_q  <= word_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
            lock_q      <= lock_d;
`ifdef PRBS_CHK_BITERR_EN
            bit_err_cnt_q <= bit_err_cnt_d;
`endif
        end
    end

    assign lock      = lock_q;
    assign err_pulse = err_pulse_q;
    assign word_cnt  = word_cnt_q;
    assign err_cnt   = err_cnt_q;
`ifdef PRBS_CHK_BITERR_EN
    assign bit_err_cnt = bit_err_cnt_q;
`endif

endmodule

// File: tb/tb_prbs7_rx_checker.sv
// Self-checking bench for prbs7_rx_checker: hand-built vector table, directed corner cases, random stimulus vs model.
module tb_prbs7_rx_checker;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned LOCK_CNT = 8;
    localparam int unsigned LOSS_CNT = 4;

    localparam int M_IDLE   = 0;
    localparam int M_SEED   = 1;
    localparam int M_HUNT   = 2;
    localparam int M_LOCKED = 3;

    logic              SYSCLK = 1'b0;
    logic              NSYSRESET;
    logic              start;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              clr_cnt;
    logic              lock;
    logic              err_pulse;
    logic [31:0]       word_cnt;
    logic [31:0]       err_cnt;
`ifdef PRBS_CHK_BITERR_EN
    logic [31:0]       bit_err_cnt;
`endif

    always #5 SYSCLK = ~SYSCLK;

    prbs7_rx_checker #(
        .DATA_W  (DATA_W),
        .LOCK_CNT(LOCK_CNT),
        .LOSS_CNT(LOSS_CNT)
    ) dut (
        .SYSCLK   (SYSCLK),
        .NSYSRESET(NSYSRESET),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .clr_cnt  (clr_cnt),
        .lock     (lock),
        .err_pulse(err_pulse),
        .word_cnt (word_cnt),
        .err_cnt  (err_cnt)
`ifdef PRBS_CHK_BITERR_EN
        ,
        .bit_err_cnt(bit_err_cnt)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // PRBS-7 from the recurrence b(n) = b(n-7) ^ b(n-6), bits held in time order in a queue.
    function automatic logic [DATA_W-1:0] prbs_word(input logic [6:0] hist);
        bit                q[$];
        bit                nb;
        logic [6:0]        h;
        logic [DATA_W-1:0] w;
        h = hist;
        w = '0;
        repeat (7) begin
            q.push_back(h[6]);
            h = h << 1;
        end
        repeat (DATA_W) begin
            nb = q[q.size()-7] ^ q[q.size()-6];
            q.push_back(nb);
            w = {w[DATA_W-2:0], nb};
        end
        return w;
    endfunction

    logic [6:0] src_hist = 7'h5A;

    task automatic next_clean(output logic [DATA_W-1:0] w);
        w        = prbs_word(src_hist);
        src_hist = w[6:0];
    endtask

    int              m_mode;
    int              m_match;
    int              m_bad;
    logic [6:0]      m_hist;
    bit              m_lock;
    bit              m_pulse;
    longint unsigned m_w, m_e, m_b;

    function automatic longint unsigned sat(input longint unsigned v);
        return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_match = 0; m_bad = 0; m_hist = 7'h7F;
        m_lock = 1'b0; m_pulse = 1'b0; m_w = 0; m_e = 0; m_b = 0;
    endtask

    task automatic model_step();
        logic [DATA_W-1:0] p;
        m_pulse = 1'b0;
        if (!start) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_SEED;
        end else if (rx_valid) begin
            p = prbs_word(m_hist);
            if (m_mode == M_SEED) begin
                m_hist = rx_data[6:0]; m_match = 0; m_mode = M_HUNT;
            end else if (m_mode == M_HUNT) begin
                m_hist = rx_data[6:0];
                if (rx_data == p) begin
                    m_match++;
                    if (m_match == int'(LOCK_CNT)) begin
                        m_mode = M_LOCKED; m_bad = 0;
                    end
                end else begin
                    m_match = 0;
                end
            end else begin
                m_hist = p[6:0];
                m_w    = sat(m_w + 1);
                if (rx_data != p) begin
                    m_e     = sat(m_e + 1);
                    m_b     = sat(m_b + 64'($countones(rx_data ^ p)));
                    m_pulse = 1'b1;
                    m_bad++;
                    if (m_bad == int'(LOSS_CNT)) m_mode = M_SEED;
                end else begin
                    m_bad = 0;
                end
            end
        end
        if (clr_cnt) begin
            m_w = 0; m_e = 0; m_b = 0;
        end
        m_lock = (m_mode == M_LOCKED);
    endtask

    task automatic check_model();
        chk("model_lock", 64'(lock), 64'(m_lock));
        chk("model_err_pulse", 64'(err_pulse), 64'(m_pulse));
        chk("model_word_cnt", 64'(word_cnt), m_w);
        chk("model_err_cnt", 64'(err_cnt), m_e);
`ifdef PRBS_CHK_BITERR_EN
        chk("model_bit_err_cnt", 64'(bit_err_cnt), m_b);
`endif
    endtask

    task automatic tick(input logic s, input logic v, input logic c, input logic [DATA_W-1:0] d);
        @(negedge SYSCLK);
        start = s; rx_valid = v; clr_cnt = c; rx_data = d;
        @(posedge SYSCLK);
        model_step();
        #1;
        check_model();
    endtask

    typedef struct {
        int          kind;   // 0 clean, 1 bit 3 flipped, 2 all zero
        bit          lock;
        bit          pulse;
        int unsigned wcnt;
        int unsigned ecnt;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(input int kind, input bit lk, input bit pl, input int unsigned w, input int unsigned e);
        vec_t r;
        r.kind = kind; r.lock = lk; r.pulse = pl; r.wcnt = w; r.ecnt = e;
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] w;
        int burst;
        bit s, v, c;

        for (int i = 0; i < 9; i++) tbl[i] = mk(0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 0, 0);
        tbl[10] = mk(0, 1, 0, 1, 0);
        tbl[11] = mk(0, 1, 0, 2, 0);
        tbl[12] = mk(1, 1, 1, 3, 1);
        tbl[13] = mk(0, 1, 0, 4, 1);
        tbl[14] = mk(2, 1, 1, 5, 2);
        tbl[15] = mk(2, 1, 1, 6, 3);
        tbl[16] = mk(2, 1, 1, 7, 4);
        tbl[17] = mk(2, 0, 1, 8, 5);
        for (int i = 18; i < 26; i++) tbl[i] = mk(0, 0, 0, 8, 5);
        tbl[26] = mk(0, 1, 0, 8, 5);
        tbl[27] = mk(0, 1, 0, 9, 5);

        NSYSRESET = 1'b0; start = 1'b0; rx_valid = 1'b0; clr_cnt = 1'b0; rx_data = '0;
        model_reset();
        #1;
        chk("reset_lock", 64'(lock), 64'd0);
        chk("reset_err_pulse", 64'(err_pulse), 64'd0);
        chk("reset_word_cnt", 64'(word_cnt), 64'd0);
        chk("reset_err_cnt", 64'(err_cnt), 64'd0);
        repeat (3) @(negedge SYSCLK);
        NSYSRESET = 1'b1;

        for (int i = 0; i < 100; i++) begin
            next_clean(w);
            tick(1'b0, 1'b1, 1'b0, w);
            chk("idle_lock", 64'(lock), 64'd0);
            chk("idle_word_cnt", 64'(word_cnt), 64'd0);
            chk("idle_err_cnt", 64'(err_cnt), 64'd0);
        end

        for (int i = 0; i < 28; i++) begin
            next_clean(w);
            if (tbl[i].kind == 1) w = w ^ DATA_W'(8);
            else if (tbl[i].kind == 2) w = '0;
            tick(1'b1, 1'b1, 1'b0, w);
            chk("tbl_lock", 64'(lock), 64'(tbl[i].lock));
            chk("tbl_err_pulse", 64'(err_pulse), 64'(tbl[i].pulse));
            chk("tbl_word_cnt", 64'(word_cnt), 64'(tbl[i].wcnt));
            chk("tbl_err_cnt", 64'(err_cnt), 64'(tbl[i].ecnt));
`ifdef PRBS_CHK_BITERR_EN
            if (i == 12 || i == 13) chk("tbl_bit_err_cnt", 64'(bit_err_cnt), 64'd1);
`endif
        end

        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                next_clean(w);
                tick(1'b1, 1'b1, 1'b0, w);
            end else begin
                tick(1'b1, 1'b0, 1'b0, DATA_W'($urandom));
            end
        end
        chk("stall_word_cnt", 64'(word_cnt), 64'd19);
        chk("stall_err_cnt", 64'(err_cnt), 64'd5);
        chk("stall_lock", 64'(lock), 64'd1);

        next_clean(w);
        tick(1'b1, 1'b1, 1'b1, w ^ DATA_W'(8));
        chk("clr_err_cnt", 64'(err_cnt), 64'd0);
        chk("clr_word_cnt", 64'(word_cnt), 64'd0);
`ifdef PRBS_CHK_BITERR_EN
        chk("clr_bit_err_cnt", 64'(bit_err_cnt), 64'd0);
`endif
        next_clean(w);
        tick(1'b1, 1'b1, 1'b0, w);
        chk("post_clr_word_cnt", 64'(word_cnt), 64'd1);
        chk("post_clr_err_cnt", 64'(err_cnt), 64'd0);

        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 399) != 0);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 149) == 0);
            if (v) begin
                next_clean(w);
                if (burst > 0) begin
                    w = '0;
                    burst--;
                end else begin
                    case ($urandom_range(0, 29))
                        0: w = '0;
                        1: w = w ^ (DATA_W'(1) << $urandom_range(0, DATA_W - 1));
                        2: w = DATA_W'($urandom);
                        3: burst = 5;
                        default: ;
                    endcase
                end
            end else begin
                w = DATA_W'($urandom);
            end
            tick(s, v, c, w);
        end

        for (int i = 0; i < 60 && !m_lock; i++) begin
            next_clean(w);
            tick(1'b1, 1'b1, 1'b0, w);
        end
        chk("pre_reset_lock", 64'(lock), 64'd1);

        @(posedge SYSCLK);
        #2;
        NSYSRESET = 1'b0;
        model_reset();
        #1;
        chk("midrst_lock", 64'(lock), 64'd0);
        chk("midrst_err_pulse", 64'(err_pulse), 64'd0);
        chk("midrst_word_cnt", 64'(word_cnt), 64'd0);
        chk("midrst_err_cnt", 64'(err_cnt), 64'd0);
`ifdef PRBS_CHK_BITERR_EN
        chk("midrst_bit_err_cnt", 64'(bit_err_cnt), 64'd0);
`endif
        start = 1'b0; rx_valid = 1'b0;
        @(posedge SYSCLK);
        @(negedge SYSCLK);
        NSYSRESET = 1'b1;

        for (int k = 0; k < 10; k++) begin
            next_clean(w);
            tick(1'b1, 1'b1, 1'b0, w);
            chk("relock_lock", 64'(lock), 64'(k == 9));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prbs7_rx_checker.md
# prbs7_rx_checker

Receive-side PRBS-7 pattern checker for the PolarFire transceiver loopback test. It consumes parallel words from the lane 0 PCS receive interface, once the PCS reports valid, comma-aligned data. It self-synchronises to the incoming PRBS-7 stream (x^7 + x^6 + 1) and declares lock. While locked it counts checked words and errored words for readback over the UART interface. It is the counterpart of the transmit-side PRBS-7 pattern generator and is released by the same `start` control as that generator.

## Interface
- `DATA_W`, 16: receive word width in bits; legal range 8..64.
- `LOCK_CNT`, 8: consecutive matching words required to declare lock; legal range 2..255.
- `LOSS_CNT`, 4: consecutive mismatching words while locked that drop lock; legal range 1..255.

- `SYSCLK`  in  1: PCS RX fabric clock; all logic is on its rising edge.
- `NSYSRESET`  in  1: reset, asynchronous assert, active-low.
- `start`  in  1: enable from the UART interface; 0 forces IDLE.
- `rx_valid`  in  1: `rx_data` qualifier (PCS ready and comma aligned).
- `rx_data`  in  DATA_W: received word; bit DATA_W-1 is oldest in time, bit 0 newest.
- `clr_cnt`  in  1: synchronous clear of `word_cnt`, `err_cnt` and `bit_err_cnt`.
- `lock`  out  1: checker locked to the PRBS-7 stream.
- `err_pulse`  out  1: one-cycle strobe for each errored word while locked.
- `word_cnt`  out  32: words checked while locked; saturating.
- `err_cnt`  out  32: errored words while locked; saturating.
- `bit_err_cnt`  out  32: errored bits while locked; present only with `PRBS_CHK_BITERR_EN`.

## Operation
- PRBS rule: for each bit n, b(n) = b(n-7) XOR b(n-6).
  - Prediction for the next word is DATA_W bits generated serially, oldest first, from a 7-bit state.
  - The state after a word is that word's 7 newest bits, `rx_data[6:0]`.
- States: IDLE, SEED, HUNT, LOCKED. In every state, `start`=0 returns to IDLE on the next edge.
- IDLE: `lock`=0, nothing is checked. `start`=1 moves to SEED.
- SEED: the first `rx_valid` word loads the state from `rx_data[6:0]`, clears `match_cnt`, and moves to HUNT.
- HUNT: each valid word is compared against the prediction.
  - Match: `match_cnt`++. When `match_cnt` reaches LOCK_CNT-1 and the current word also matches, move to LOCKED.
  - Mismatch: `match_cnt` is cleared.
  - Match or mismatch, the state is reloaded from the received word (self-synchronising).
- LOCKED: the state advances from the internal prediction only, never from received data, so one corrupted bit counts as exactly one errored word.
  - Each valid word increments `word_cnt`.
  - Mismatch: `err_cnt`++, `err_pulse`=1, `bad_run`++. When `bad_run` reaches LOSS_CNT, move to SEED with `lock`=0.
  - Match: clears `bad_run`.
- `rx_valid`=0 stalls all state, prediction and counters in every state. No word is counted or checked.
- Counters are valid only in LOCKED, are held in every other state, and saturate at 32'hFFFF_FFFF.
- `clr_cnt`=1 zeroes all counters. It takes priority over an increment in the same cycle: that word is not counted.
- `lock` drops from 1 to 0 when the FSM leaves LOCKED; the counters keep their values.

## Timing
- Reset values: state IDLE; `lock`, `err_pulse` = 0; all counters, `match_cnt`, `bad_run` = 0; prediction state 7'h7F.
- Compare, `err_pulse`, counter increments and state updates are all registered: they are visible one cycle after the `rx_valid` word is sampled.
- `lock` rises in the cycle after the edge that samples the LOCK_CNT-th consecutive matching HUNT word.
- `lock` falls in the cycle after the LOSS_CNT-th consecutive LOCKED mismatch. That same word still increments `err_cnt` and still asserts `err_pulse`.
- Minimum time to lock from `start`: 1 + LOCK_CNT valid words after the first SEED word.
- Asserting `NSYSRESET` at any point, including mid-word or while LOCKED, clears everything immediately. Deassertion must be synchronous to `SYSCLK`, which is guaranteed externally.
- Back-to-back `rx_valid` every cycle is supported at full rate; there is no backpressure.

## Configuration
- `PRBS_CHK_BITERR_EN` defined:
  - The `bit_err_cnt` port exists.
  - Each LOCKED mismatch adds popcount(`rx_data` XOR prediction) to `bit_err_cnt`, saturating.
  - Cleared by `clr_cnt` and reset.
  - Latency is identical to `err_cnt`.
- Not defined: the port and its popcount logic are absent, and all other behaviour is unchanged.

## Test plan
- Reset and idle: `start`=0, clean PRBS-7 with `rx_valid`=1 for 100 cycles -> `lock`=0 and all counters 0 throughout.
- Clean acquisition (DATA_W=16, LOCK_CNT=8): `start`=1, continuous clean stream -> `lock`=1 exactly 10 cycles after the first valid word; after 1000 further words, `word_cnt`=1000 and `err_cnt`=0.
- Single-bit error: while locked, flip bit 3 of one word -> exactly one `err_pulse`, `err_cnt`=1, `bit_err_cnt`=1 when enabled, and `lock` stays 1.
- Loss of lock (LOSS_CNT=4): 4 consecutive all-zero words while locked -> `err_cnt`+4 and `lock`=0 the cycle after the 4th. Clean data resumes -> relock after 9 valid words.
- Stall and clear:
  - `rx_valid` toggled 1/0 while locked -> `word_cnt` advances only on valid cycles and `err_cnt` stays 0.
  - `clr_cnt` coinciding with an errored word -> `err_cnt`=0 the next cycle.
- Mid-operation reset: `NSYSRESET` pulsed low for 1 cycle while locked -> `lock`=0 and all counters 0 immediately; the checker reacquires the lock afterwards.
